// File: rtl/ldtu_sample_encoder_if.sv
// Sample-in / word-out bundle between the gain-selection stage, the encoder and the serializer.
// The master drives samples and the enable; the slave (encoder) returns packed words.
interface ldtu_sample_encoder_if;
  logic        ENC_EN;
  logic [12:0] DATA_to_enc;
  logic        baseline_flag;
  logic [31:0] DATA_32;
  logic        data_valid;

  modport master (
    output ENC_EN,
    output DATA_to_enc,
    output baseline_flag,
    input  DATA_32,
    input  data_valid
  );

  modport slave (
    input  ENC_EN,
    input  DATA_to_enc,
    input  baseline_flag,
    output DATA_32,
    output data_valid
  );
endinterface

// File: rtl/ldtu_sample_encoder.sv
// Packs 13-bit LiTe-DTU samples into 32-bit words: five 6-bit baseline samples or two signal samples.
// A type change or ENC_EN low flushes a partial word with a count/single header.
module ldtu_sample_encoder #(
  parameter int Nbits_12  = 12,
  parameter int Nbits_6   = 6,
  parameter int NBase     = 5,
  parameter int WordWidth = 32
) (
  input  logic                  CLK,
  input  logic                  rst_b,
  ldtu_sample_encoder_if.slave  enc_if
);
  localparam int SW = Nbits_12 + 1;
  localparam int AW = (NBase - 1) * Nbits_6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BASE = 2'd1,
    SIG  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WordWidth-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;

  logic [SW-1:0]          smp;
  logic [Nbits_6-1:0]     base_smp;
  logic [4:0]             shamt;

  assign smp      = enc_if.DATA_to_enc;
  assign base_smp = smp[Nbits_6-1:0];

  function automatic logic [WordWidth-1:0] partial_word(input logic [2:0] cnt, input logic [AW-1:0] acc);
    return {4'b1110, 1'b0, cnt, acc};
  endfunction

  function automatic logic [WordWidth-1:0] single_word(input logic [AW-1:0] acc);
    return {6'b001011, 13'd0, acc[SW-1:0]};
  endfunction

  // Next-state, accumulator and output-word computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    shamt   = {2'b00, cnt_q} * 5'd6;

    if (!enc_if.ENC_EN) begin
      // Disabled: the sample is dropped and whatever is held goes out as a partial/single word.
      case (state_q)
        BASE: begin
          data_d  = partial_word(cnt_q, acc_q);
          valid_d = 1'b1;
        end
        SIG: begin
          data_d  = single_word(acc_q);
          valid_d = 1'b1;
        end
        default: begin
          data_d = data_q;
        end
      endcase
      state_d = IDLE;
      cnt_d   = 3'd0;
      acc_d   = {AW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_if.baseline_flag) begin
            state_d = BASE;
            cnt_d   = 3'd1;
            acc_d   = {{(AW-Nbits_6){1'b0}}, base_smp};
          end else begin
            state_d = SIG;
            cnt_d   = 3'd0;
            acc_d   = {{(AW-SW){1'b0}}, smp};
          end
        end
        BASE: begin
          if (enc_if.baseline_flag) begin
            if (cnt_q == 3'(NBase - 1)) begin
              data_d  = {2'b01, base_smp, acc_q};
              valid_d = 1'b1;
              state_d = IDLE;
              cnt_d   = 3'd0;
              acc_d   = {AW{1'b0}};
            end else begin
              acc_d = acc_q | ({{(AW-Nbits_6){1'b0}}, base_smp} << shamt);
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            data_d  = partial_word(cnt_q, acc_q);
            valid_d = 1'b1;
            state_d = SIG;
            cnt_d   = 3'd0;
            acc_d   = {{(AW-SW){1'b0}}, smp};
          end
        end
        SIG: begin
          if (enc_if.baseline_flag) begin
            data_d  = single_word(acc_q);
            valid_d = 1'b1;
            state_d = BASE;
            cnt_d   = 3'd1;
            acc_d   = {{(AW-Nbits_6){1'b0}}, base_smp};
          end else begin
            data_d  = {6'b001010, smp, acc_q[SW-1:0]};
            valid_d = 1'b1;
            state_d = IDLE;
            cnt_d   = 3'd0;
            acc_d   = {AW{1'b0}};
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          acc_d   = {AW{1'b0}};
        end
      endcase
    end
  end

  // State, accumulator and registered output word.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      acc_q   <= {AW{1'b0}};
      data_q  <= {WordWidth{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign enc_if.DATA_32    = data_q;
  assign enc_if.data_valid = valid_q;
endmodule
